// File: rtl/tic_tac_toe_ai_mover_pkg.sv
// Shared definitions for the tic-tac-toe move generator: cell codes,
// line/preference tables, FSM state encoding and a small mod-9 helper.
package tic_tac_toe_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  localparam logic [1:0] WHO_NONE   = 2'b00;

  // Cell indices of the eight winning lines: rows, columns, diagonals.
  localparam logic [3:0] LINES [8][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  // Fallback order: centre, corners, edges.
  localparam logic [3:0] PREF_ORDER [9] = '{
    4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNAP,
    ST_WIN,
    ST_BLOCK,
    ST_PREF,
    ST_ISSUE
  } state_t;

  // Reduce a value in 0..17 to 0..8.
  function automatic logic [3:0] mod9(input logic [4:0] v);
    logic [4:0] r;
    r = (v >= 5'd9) ? (v - 5'd9) : v;
    return r[3:0];
  endfunction

endpackage

// File: rtl/tic_tac_toe_ai_mover_if.sv
// Connection bundle between the move generator and the game block.
// master: the game side (drives board, result and start requests).
// slave:  the move generator (drives the move strobe and status).
interface tic_tac_toe_ai_mover_if;

  logic       start;
  logic [1:0] pos1;
  logic [1:0] pos2;
  logic [1:0] pos3;
  logic [1:0] pos4;
  logic [1:0] pos5;
  logic [1:0] pos6;
  logic [1:0] pos7;
  logic [1:0] pos8;
  logic [1:0] pos9;
  logic [1:0] who;
  logic       pc;
  logic [3:0] computer_position;
  logic       busy;
  logic       no_move;

  modport master (
    output start, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, who,
    input  pc, computer_position, busy, no_move
  );

  modport slave (
    input  start, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, who,
    output pc, computer_position, busy, no_move
  );

endinterface

// File: rtl/tic_tac_toe_ai_mover_line_eval.sv
// Combinational check of one three-cell line: reports a hit when two cells
// carry the requested mark and the third is empty, plus the empty slot (0..2).
// Occupied (11) cells never match the mark or the empty code.
module ttt_line_eval
  import tic_tac_toe_pkg::*;
(
  input  logic [1:0] cell_a,
  input  logic [1:0] cell_b,
  input  logic [1:0] cell_c,
  input  logic [1:0] mark,
  output logic       hit,
  output logic [1:0] slot
);

  // Exactly one of the three two-mark-plus-empty patterns can match.
  always_comb begin
    hit  = 1'b0;
    slot = 2'd0;
    if (cell_a == CELL_EMPTY && cell_b == mark && cell_c == mark) begin
      hit  = 1'b1;
      slot = 2'd0;
    end else if (cell_a == mark && cell_b == CELL_EMPTY && cell_c == mark) begin
      hit  = 1'b1;
      slot = 2'd1;
    end else if (cell_a == mark && cell_b == mark && cell_c == CELL_EMPTY) begin
      hit  = 1'b1;
      slot = 2'd2;
    end
  end

endmodule

// File: rtl/tic_tac_toe_ai_mover.sv
// Computer move generator for the tic-tac-toe game block.
// On start it snapshots the board, then scans lines for a win, then for a
// block, then falls back to a preference order, and finally holds pc high
// with a stable computer_position for PC_HOLD cycles.
// Optional feature macro: TTT_LFSR_OPENING_EN -- when defined, the fallback
// scan starts at a pseudo-random cell taken from an 8-bit LFSR.
module tic_tac_toe_ai_mover
  import tic_tac_toe_pkg::*;
#(
  parameter int         PC_HOLD   = 5,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                    clock,
  input  logic                    reset,
  tic_tac_toe_ai_mover_if.slave   bus
);

  localparam int HOLD_W = (PC_HOLD > 1) ? $clog2(PC_HOLD) : 1;

  // Elaboration-time parameter sanity checks.
  if (PC_HOLD < 1) begin : g_bad_hold
    $error("PC_HOLD must be at least 1");
  end
  if (LFSR_SEED == 8'h00) begin : g_bad_seed
    $error("LFSR_SEED must be non-zero");
  end

  state_t            state;
  logic              pc_q;
  logic [3:0]        cpos_q;
  logic              busy_q;
  logic              no_move_q;
  logic [2:0]        line_cnt;
  logic [3:0]        cell_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  logic [1:0]        snap [9];
  logic              board_has_empty;

  logic [1:0]        mark;
  logic              line_hit;
  logic [1:0]        line_slot;
  logic [3:0]        line_target;
  logic [3:0]        pref_idx;
  logic              pref_free;

  // Free-cell test on the live inputs, used only in the SNAP cycle when the
  // snapshot is being captured from these very same values.
  always_comb begin
    board_has_empty = (bus.pos1 == CELL_EMPTY) || (bus.pos2 == CELL_EMPTY) ||
                      (bus.pos3 == CELL_EMPTY) || (bus.pos4 == CELL_EMPTY) ||
                      (bus.pos5 == CELL_EMPTY) || (bus.pos6 == CELL_EMPTY) ||
                      (bus.pos7 == CELL_EMPTY) || (bus.pos8 == CELL_EMPTY) ||
                      (bus.pos9 == CELL_EMPTY);
  end

  // Board snapshot: captured once in SNAP, later input changes are ignored.
  always_ff @(posedge clock) begin
    if (state == ST_SNAP) begin
      snap[0] <= bus.pos1;
      snap[1] <= bus.pos2;
      snap[2] <= bus.pos3;
      snap[3] <= bus.pos4;
      snap[4] <= bus.pos5;
      snap[5] <= bus.pos6;
      snap[6] <= bus.pos7;
      snap[7] <= bus.pos8;
      snap[8] <= bus.pos9;
    end
  end

  // WIN looks for two O marks, BLOCK for two X marks; one evaluator serves both.
  assign mark = (state == ST_BLOCK) ? CELL_X : CELL_O;

  ttt_line_eval u_line_eval (
    .cell_a (snap[LINES[line_cnt][0]]),
    .cell_b (snap[LINES[line_cnt][1]]),
    .cell_c (snap[LINES[line_cnt][2]]),
    .mark   (mark),
    .hit    (line_hit),
    .slot   (line_slot)
  );

  assign line_target = LINES[line_cnt][line_slot];

`ifdef TTT_LFSR_OPENING_EN
  logic [7:0] lfsr;
  logic [3:0] pref_start;

  // Fibonacci LFSR, taps 8,6,5,4, free-running every cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  // Latch the random starting cell on the BLOCK -> PREF transition.
  always_ff @(posedge clock) begin
    if (state == ST_BLOCK && !line_hit && line_cnt == 3'd7) begin
      pref_start <= mod9({1'b0, lfsr[3:0]});
    end
  end

  assign pref_idx = mod9({1'b0, pref_start} + {1'b0, cell_cnt});
`else
  assign pref_idx = PREF_ORDER[cell_cnt];
`endif

  assign pref_free = (snap[pref_idx] == CELL_EMPTY);

  // Main control FSM; all outputs are registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      pc_q      <= 1'b0;
      cpos_q    <= 4'd0;
      busy_q    <= 1'b0;
      no_move_q <= 1'b0;
      line_cnt  <= 3'd0;
      cell_cnt  <= 4'd0;
      hold_cnt  <= '0;
    end else begin
      no_move_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state  <= ST_SNAP;
            busy_q <= 1'b1;
          end
        end
        ST_SNAP: begin
          if (bus.who != WHO_NONE || !board_has_empty) begin
            no_move_q <= 1'b1;
            busy_q    <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            line_cnt <= 3'd0;
            state    <= ST_WIN;
          end
        end
        ST_WIN: begin
          if (line_hit) begin
            cpos_q   <= line_target;
            pc_q     <= 1'b1;
            hold_cnt <= '0;
            state    <= ST_ISSUE;
          end else if (line_cnt == 3'd7) begin
            line_cnt <= 3'd0;
            state    <= ST_BLOCK;
          end else begin
            line_cnt <= line_cnt + 3'd1;
          end
        end
        ST_BLOCK: begin
          if (line_hit) begin
            cpos_q   <= line_target;
            pc_q     <= 1'b1;
            hold_cnt <= '0;
            state    <= ST_ISSUE;
          end else if (line_cnt == 3'd7) begin
            cell_cnt <= 4'd0;
            state    <= ST_PREF;
          end else begin
            line_cnt <= line_cnt + 3'd1;
          end
        end
        ST_PREF: begin
          if (pref_free) begin
            cpos_q   <= pref_idx;
            pc_q     <= 1'b1;
            hold_cnt <= '0;
            state    <= ST_ISSUE;
          end else if (cell_cnt == 4'd8) begin
            // Unreachable given the SNAP free-cell check; recover cleanly.
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            cell_cnt <= cell_cnt + 4'd1;
          end
        end
        ST_ISSUE: begin
          if (hold_cnt == HOLD_W'(PC_HOLD - 1)) begin
            pc_q   <= 1'b0;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          pc_q   <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.pc                = pc_q;
  assign bus.computer_position = cpos_q;
  assign bus.busy              = busy_q;
  assign bus.no_move           = no_move_q;

endmodule

// File: tb/tb_tic_tac_toe_ai_mover.sv
// Self-checking bench for tic_tac_toe_ai_mover (default build, fixed
// preference order). A behavioural model decides each move and its latency
// from the game rules; directed boards plus random boards are exercised.
module tb_tic_tac_toe_ai_mover;

  localparam int PC_HOLD = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  tic_tac_toe_ai_mover_if bus ();

  tic_tac_toe_ai_mover #(
    .PC_HOLD   (PC_HOLD),
    .LFSR_SEED (8'hA5)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference tables, written from the game rules.
  int ref_lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8},
                           '{0,3,6}, '{1,4,7}, '{2,5,8},
                           '{0,4,8}, '{2,4,6}};
  int ref_pref [9] = '{4,0,2,6,8,1,3,5,7};

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural model: decision plus number of edges from the start edge
  // (counted as 1) to the edge that raises pc. Two edges reach the scan
  // (IDLE->SNAP, SNAP->WIN), then one edge per line or cell examined.
  task automatic model_move(input logic [1:0] b [9], input logic [1:0] w,
                            output bit drop, output int tgt, output int lat);
    int marks;
    int empties;
    int hole;
    bit any_empty;
    logic [1:0] want;
    drop = 1'b0;
    tgt  = -1;
    lat  = 2;
    any_empty = 1'b0;
    for (int i = 0; i < 9; i++) if (b[i] == 2'b00) any_empty = 1'b1;
    if (w != 2'b00 || !any_empty) begin
      drop = 1'b1;
      return;
    end
    for (int phase = 0; phase < 2; phase++) begin
      want = (phase == 0) ? 2'b10 : 2'b01;
      for (int l = 0; l < 8; l++) begin
        lat++;
        marks = 0; empties = 0; hole = 0;
        for (int k = 0; k < 3; k++) begin
          if (b[ref_lines[l][k]] == want) marks++;
          if (b[ref_lines[l][k]] == 2'b00) begin
            empties++;
            hole = ref_lines[l][k];
          end
        end
        if (marks == 2 && empties == 1) begin
          tgt = hole;
          return;
        end
      end
    end
    for (int k = 0; k < 9; k++) begin
      lat++;
      if (b[ref_pref[k]] == 2'b00) begin
        tgt = ref_pref[k];
        return;
      end
    end
  endtask

  task automatic drive_board(input logic [1:0] b [9], input logic [1:0] w);
    bus.pos1 = b[0]; bus.pos2 = b[1]; bus.pos3 = b[2];
    bus.pos4 = b[3]; bus.pos5 = b[4]; bus.pos6 = b[5];
    bus.pos7 = b[6]; bus.pos8 = b[7]; bus.pos9 = b[8];
    bus.who  = w;
  endtask

  task automatic scramble_inputs();
    bus.pos1 = 2'($urandom); bus.pos2 = 2'($urandom); bus.pos3 = 2'($urandom);
    bus.pos4 = 2'($urandom); bus.pos5 = 2'($urandom); bus.pos6 = 2'($urandom);
    bus.pos7 = 2'($urandom); bus.pos8 = 2'($urandom); bus.pos9 = 2'($urandom);
    bus.who  = 2'($urandom);
  endtask

  // One start request observed over a fixed 40-edge window. Called at
  // posedge+#1 with the DUT idle.
  task automatic run_move(input string name, input logic [1:0] b [9],
                          input logic [1:0] w, input bit repulse,
                          input bit scramble, input bit rst_mid);
    bit drop;
    int tgt, lat;
    int first_pc, pc_cnt, pos_first, nm_cnt, nm_edge;
    bit stable, busy1, busy2, rst_pend, rst_done;
    model_move(b, w, drop, tgt, lat);
    drive_board(b, w);
    first_pc = -1; pc_cnt = 0; pos_first = 0; nm_cnt = 0; nm_edge = 0;
    stable = 1'b1; busy1 = 1'b0; busy2 = 1'b0; rst_pend = 1'b0; rst_done = 1'b0;
    bus.start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (rst_pend) begin
        check_eq({name, ".rst_pc"}, int'(bus.pc), 0);
        check_eq({name, ".rst_busy"}, int'(bus.busy), 0);
        check_eq({name, ".rst_pos"}, int'(bus.computer_position), 0);
        rst = 1'b0;
        rst_pend = 1'b0;
      end
      if (bus.pc) begin
        if (first_pc < 0) begin
          first_pc  = n;
          pos_first = int'(bus.computer_position);
        end else if (int'(bus.computer_position) != pos_first) begin
          stable = 1'b0;
        end
        pc_cnt++;
      end
      if (bus.no_move) begin
        nm_cnt++;
        nm_edge = n;
      end
      if (n == 1) busy1 = bus.busy;
      if (n == 2) busy2 = bus.busy;
      if (repulse && (n == 4 || (first_pc > 0 && n == first_pc + 1)))
        bus.start = 1'b1;
      if (scramble && n >= 2) scramble_inputs();
      if (rst_mid && !rst_done && pc_cnt == 2) begin
        rst = 1'b1;
        rst_done = 1'b1;
        rst_pend = 1'b1;
      end
    end
    drive_board(b, 2'b00);
    if (drop) begin
      check_eq({name, ".no_move_cnt"}, nm_cnt, 1);
      check_eq({name, ".no_move_edge"}, nm_edge, 2);
      check_eq({name, ".pc_cnt"}, pc_cnt, 0);
      check_eq({name, ".busy_snap"}, int'(busy1), 1);
      check_eq({name, ".busy_after"}, int'(busy2), 0);
    end else begin
      check_eq({name, ".latency"}, first_pc, lat);
      check_eq({name, ".position"}, pos_first, tgt);
      check_eq({name, ".pos_stable"}, int'(stable), 1);
      check_eq({name, ".no_move_cnt"}, nm_cnt, 0);
      check_eq({name, ".busy_snap"}, int'(busy1), 1);
      check_eq({name, ".busy_end"}, int'(bus.busy), 0);
      if (rst_mid) begin
        check_eq({name, ".pc_cnt_rst"}, pc_cnt, 2);
      end else begin
        check_eq({name, ".pc_cnt"}, pc_cnt, PC_HOLD);
        check_eq({name, ".pos_held"}, int'(bus.computer_position), tgt);
      end
    end
  endtask

  logic [1:0] brd [9];
  logic [1:0] rwho;
  int         r;

  initial begin
    bus.start = 1'b0;
    brd = '{default: 2'b00};
    drive_board(brd, 2'b00);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset.pc", int'(bus.pc), 0);
    check_eq("reset.pos", int'(bus.computer_position), 0);
    check_eq("reset.busy", int'(bus.busy), 0);
    check_eq("reset.no_move", int'(bus.no_move), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Win on the first line.
    brd = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1};
    run_move("win", brd, 2'b00, 1'b0, 1'b0, 1'b0);
    // Block on the first line.
    brd = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
    run_move("block", brd, 2'b00, 1'b0, 1'b0, 1'b0);
    // Empty board falls through to the centre.
    brd = '{default: 2'b00};
    run_move("empty", brd, 2'b00, 1'b0, 1'b0, 1'b0);
    // Centre and a corner taken: next preference is cell 2.
    brd = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
    run_move("pref2", brd, 2'b00, 1'b0, 1'b0, 1'b0);
    // Game already decided.
    brd = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
    run_move("who", brd, 2'b01, 1'b0, 1'b0, 1'b0);
    // Full board, draw layout.
    brd = '{2'd1, 2'd2, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1};
    run_move("full", brd, 2'b00, 1'b0, 1'b0, 1'b0);
    // Occupied (11) cells never count as O, X or empty.
    brd = '{2'd2, 2'd3, 2'd0, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
    run_move("occ", brd, 2'b00, 1'b0, 1'b0, 1'b0);
    // Reset during the second pc cycle, then a normal move right after.
    brd = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1};
    run_move("rstmid", brd, 2'b00, 1'b0, 1'b0, 1'b1);
    brd = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
    run_move("after_rst", brd, 2'b00, 1'b0, 1'b0, 1'b0);
    // Start re-pulsed during the scan and during issue; inputs disturbed.
    brd = '{default: 2'b00};
    run_move("repulse", brd, 2'b00, 1'b1, 1'b1, 1'b0);

    // Random boards.
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 9; i++) begin
        r = $urandom_range(0, 9);
        brd[i] = (r < 4) ? 2'b00 : (r < 6) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11;
      end
      rwho = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_move($sformatf("rand%0d", it), brd, rwho,
               (rwho == 2'b00) && ($urandom_range(0, 1) == 1),
               $urandom_range(0, 1) == 1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
